pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, elastic inter-stage pipeline register for the pipelined RISC-V core, the generic replacement for the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle between two stages using a valid/ready handshake. It supports stall backpressure, synchronous flush (bubble insertion), an optional two-entry skid buffer for full throughput, and a saturating stall-cycle counter for performance monitoring.

## Interface
- CTRL_W, 8: width of the control bundle (RegWrite, ResultSrc, MemWrite, …); zeroed on bubble.
- DATA_W, 101: width of the data bundle (ALUResult, WriteData, Rd, PCPlus4, …).
- SKID, 1: 1 selects the two-entry skid buffer with registered `in_ready`; 0 selects a single register with combinational `in_ready`.
- CNT_W, 16: width of the stall counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  synchronous flush: discard all held entries.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  the output entry is valid.
- out_ready  in  1  downstream accepts the output entry.
- out_ctrl  out  CTRL_W  control bundle; all-zero whenever `out_valid`=0.
- out_data  out  DATA_W  data bundle; holds its last value when invalid.
- stall_cnt  out  CNT_W  count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Accept: `in_valid && in_ready`. Emit: `out_valid && out_ready`.
- Priority at each clock edge:
  - `rst`=0 is highest.
  - `flush`=1 is next.
  - Normal transfer otherwise.
- Reset (rst=0): main and skid valid bits cleared; all ctrl and data registers cleared to 0; `stall_cnt`=0.
- Outputs during reset: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=0.
- Flush:
  - Clears both valid bits and both ctrl registers to 0. Data registers keep their values.
  - `in_ready` is forced 0 combinationally while `flush`=1, so no entry is accepted in a flush cycle.
  - `stall_cnt` is not affected.
- SKID=0:
  - `in_ready` = `!out_valid || out_ready`.
  - On accept, the main register loads the input and `out_valid` is set.
  - On emit without accept, `out_valid` is cleared.
- SKID=1, `in_ready` = `!skid_valid` (registered). Transitions:
  - EMPTY: accept → ONE.
  - ONE: accept with emit → ONE, main reloaded from input. Accept without emit → TWO, input goes to skid. Emit only → EMPTY.
  - TWO: emit → ONE, skid moves to main, skid cleared. No accept is possible in TWO.
- Ordering: entries leave in acceptance order. No entry is duplicated or lost except by flush.
- Counter: increments when `out_valid && !out_ready` and saturates at 2^CNT_W−1 (no wrap). It is cleared only by reset.

## Timing
- Latency: one cycle from accept to `out_valid`; the entry is visible on the cycle after the accepting edge.
- Throughput: one entry per cycle in both modes while `out_ready`=1.
- SKID=1 fully breaks the ready path: `in_ready` depends only on state and `flush`.
- `out_ctrl`/`out_data` are registered outputs (no combinational input→output path). `out_ctrl` is gated to 0 when `out_valid`=0.
- A flush in the same cycle as an emit still counts as the emit; downstream samples on that edge. The stage is empty on the next cycle.
- Reset released mid-stream: the first accept is possible one cycle after `rst` returns to 1.

## Structure
- Shared package `pipe_pkg`:
  - The per-stage CTRL_W/DATA_W constants: IFID, IDEX, EXMEM, MEMWB.
  - Packed structs for each stage's ctrl/data bundles.
  - The `ResultSrc` encoding.
- Sub-module `pipe_sat_counter` (CNT_W, enable, saturating, sync active-low reset) implements `stall_cnt`.
- The skid/main datapath stays inline, using generate on SKID.

## Test plan
- Reset: hold rst=0 for 3 cycles with in_valid=1 and in_data=0x5A → out_valid=0, out_ctrl=0, out_data=0, in_ready=0, stall_cnt=0. The first accept occurs on the cycle after release.
- Streaming, SKID=1, out_ready=1: send entries 1..8 back-to-back → out_data=1..8 on consecutive cycles starting one cycle after the first accept; in_ready stays 1 throughout.
- Backpressure, SKID=1: accept A and B, then hold out_ready=0 for 5 cycles.
  - Expected: in_ready=0 after B; out_data=A held; stall_cnt=5.
  - On release: A, then B, then in_ready=1.
- Flush: with 2 entries held (ctrl=0xFF), assert flush with in_valid=1 → in_ready=0 that cycle; next cycle out_valid=0, out_ctrl=0x00, stall_cnt unchanged.
- SKID=0 bypass: hold out_ready=0 with out_valid=1 → in_ready=0. Then assert out_ready=1 and in_valid=1 in the same cycle → simultaneous emit and accept, and the new entry appears the next cycle.
- Saturation, CNT_W=4: stall for 20 cycles → stall_cnt=15, not 4.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline bundle definitions for the RISC-V core.
// Stage ctrl/data layouts and their widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_IMM = 2'd3
  } result_src_e;

  typedef struct packed {
    logic        pred_taken;
  } ifid_ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } ifid_data_t;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
  } idex_ctrl_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [31:0] pc_plus4;
  } idex_data_t;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        csr_write;
  } exmem_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } exmem_data_t;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
  } memwb_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } memwb_data_t;

  localparam int IFID_CTRL_W  = $bits(ifid_ctrl_t);
  localparam int IFID_DATA_W  = $bits(ifid_data_t);
  localparam int IDEX_CTRL_W  = $bits(idex_ctrl_t);
  localparam int IDEX_DATA_W  = $bits(idex_data_t);
  localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);
  localparam int EXMEM_DATA_W = $bits(exmem_data_t);
  localparam int MEMWB_CTRL_W = $bits(memwb_ctrl_t);
  localparam int MEMWB_DATA_W = $bits(memwb_data_t);

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bundle link between two pipeline stages.
// master drives valid/ctrl/data, slave drives ready.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (
    output valid, ctrl, data,
    input  ready
  );

  modport slave (
    input  valid, ctrl, data,
    output ready
  );
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable.
// Holds at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // count enabled cycles, stick at the top value
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register with flush and stall counter.
// SKID=1 adds a second entry so in_ready is registered.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  output logic [CNT_W-1:0] stall_cnt
);

  logic              live;
  logic              m_v;
  logic [CTRL_W-1:0] m_c;
  logic [DATA_W-1:0] m_d;
  logic              acc;
  logic              emit;

  assign acc      = up.valid && up.ready;
  assign emit     = m_v && dn.ready;
  assign dn.valid = m_v;
  assign dn.ctrl  = m_v ? m_c : '0;
  assign dn.data  = m_d;

  // one cycle of quiet after reset before taking entries
  always_ff @(posedge clk) begin
    if (!rst) live <= 1'b0;
    else      live <= 1'b1;
  end

  if (SKID != 0) begin : g_skid
    logic              s_v;
    logic [CTRL_W-1:0] s_c;
    logic [DATA_W-1:0] s_d;

    assign up.ready = live && !s_v && !flush;

    // main/skid pair: skid only fills when main is stuck
    always_ff @(posedge clk) begin
      if (!rst) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
        m_c <= '0;
        s_c <= '0;
        m_d <= '0;
        s_d <= '0;
      end else if (flush) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
        m_c <= '0;
        s_c <= '0;
      end else begin
        unique case (1'b1)
          s_v && emit: begin
            m_c <= s_c;
            m_d <= s_d;
            s_v <= 1'b0;
          end
          acc && (!m_v || emit): begin
            m_v <= 1'b1;
            m_c <= up.ctrl;
            m_d <= up.data;
          end
          acc && m_v && !emit: begin
            s_v <= 1'b1;
            s_c <= up.ctrl;
            s_d <= up.data;
          end
          !s_v && !acc && emit: begin
            m_v <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end else begin : g_single
    assign up.ready = live && !flush && (!m_v || dn.ready);

    // single entry, refilled in the same cycle it drains
    always_ff @(posedge clk) begin
      if (!rst) begin
        m_v <= 1'b0;
        m_c <= '0;
        m_d <= '0;
      end else if (flush) begin
        m_v <= 1'b0;
        m_c <= '0;
      end else if (acc) begin
        m_v <= 1'b1;
        m_c <= up.ctrl;
        m_d <= up.data;
      end else if (emit) begin
        m_v <= 1'b0;
      end
    end
  end

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall (
    .clk (clk),
    .rst (rst),
    .en  (m_v && !dn.ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configs against a queue model.
// DUT0 SKID=1/CNT16, DUT1 SKID=0/CNT16, DUT2 SKID=1/CNT4.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = 8;
  localparam int DW = 101;
  localparam int N  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          iv   [N];
  logic          fl   [N];
  logic          ordy [N];
  logic [CW-1:0] ic   [N];
  logic [DW-1:0] id   [N];
  logic          ir   [N];
  logic          ov   [N];
  logic [CW-1:0] oc   [N];
  logic [DW-1:0] od   [N];
  logic [15:0]   sc   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int SK = (g == 1) ? 0 : 1;
    localparam int CN = (g == 2) ? 4 : 16;
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) ui ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) uo ();
    logic [CN-1:0] cnt;
    assign ui.valid = iv[g];
    assign ui.ctrl  = ic[g];
    assign ui.data  = id[g];
    assign ir[g]    = ui.ready;
    assign uo.ready = ordy[g];
    assign ov[g]    = uo.valid;
    assign oc[g]    = uo.ctrl;
    assign od[g]    = uo.data;
    assign sc[g]    = 16'(cnt);
    pipe_stage_reg #(
      .CTRL_W (CW),
      .DATA_W (DW),
      .SKID   (SK),
      .CNT_W  (CN)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (fl[g]),
      .up        (ui),
      .dn        (uo),
      .stall_cnt (cnt)
    );
  end

  int ncmp = 0;
  int nbad = 0;

  task automatic chk(string nm, int k, logic [127:0] act, logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s[%0d] got %0h want %0h", nm, k, act, exp);
    end
  endtask

  // behavioural model: a FIFO of accepted entries, depth 2 or 1
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq    [N][$];
  logic [DW-1:0] mdat  [N];
  int            mcnt  [N];
  bit            mlive [N];
  int            cmax  [N] = '{65535, 65535, 15};
  bit            mskid [N] = '{1'b1, 1'b0, 1'b1};
  bit            go = 1'b0;

  function automatic bit mrdy(int k);
    bit room;
    room = mskid[k] ? (mq[k].size() < 2)
                    : (mq[k].size() == 0 || ordy[k]);
    return mlive[k] && !fl[k] && room;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      bit a;
      bit e;
      a = iv[k] && mrdy(k);
      e = (mq[k].size() > 0) && ordy[k];
      if (!rst) begin
        mq[k].delete();
        mcnt[k]  = 0;
        mdat[k]  = '0;
        mlive[k] = 1'b0;
      end else begin
        if (mq[k].size() > 0 && !ordy[k] && mcnt[k] < cmax[k])
          mcnt[k]++;
        if (e) void'(mq[k].pop_front());
        if (fl[k]) mq[k].delete();
        else if (a) mq[k].push_back('{c: ic[k], d: id[k]});
        mlive[k] = 1'b1;
        if (mq[k].size() > 0) mdat[k] = mq[k][0].d;
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      for (int k = 0; k < N; k++) begin
        bit           v;
        logic [CW-1:0] c;
        v = mq[k].size() > 0;
        c = v ? mq[k][0].c : '0;
        chk("out_valid", k, 128'(ov[k]), 128'(v));
        chk("out_ctrl", k, 128'(oc[k]), 128'(c));
        chk("out_data", k, 128'(od[k]), 128'(mdat[k]));
        chk("in_ready", k, 128'(ir[k]), 128'(mrdy(k)));
        chk("stall_cnt", k, 128'(sc[k]), 128'(mcnt[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1;
      ic[k] = '0;   id[k] = '0;
    end
    iv[0] = 1'b1; ic[0] = 8'h11; id[0] = DW'(8'h5A);
    tick();
    go = 1'b1;
    tick();
    tick();
    chk("rst_ov", 0, 128'(ov[0]), 128'(0));
    chk("rst_oc", 0, 128'(oc[0]), 128'(0));
    chk("rst_od", 0, 128'(od[0]), 128'(0));
    chk("rst_ir", 0, 128'(ir[0]), 128'(0));
    chk("rst_sc", 0, 128'(sc[0]), 128'(0));
    rst = 1'b1;
    tick();
    chk("rel_ov", 0, 128'(ov[0]), 128'(0));
    chk("rel_ir", 0, 128'(ir[0]), 128'(1));
    tick();
    chk("first_ov", 0, 128'(ov[0]), 128'(1));
    chk("first_od", 0, 128'(od[0]), 128'(8'h5A));
    iv[0] = 1'b0;
    tick();

    for (int i = 1; i <= 8; i++) begin
      iv[0] = 1'b1; ic[0] = CW'(i); id[0] = DW'(i);
      tick();
      chk("stream_od", 0, 128'(od[0]), 128'(i));
      chk("stream_ir", 0, 128'(ir[0]), 128'(1));
    end
    iv[0] = 1'b0;
    tick();

    ordy[0] = 1'b0;
    iv[0] = 1'b1; ic[0] = 8'h0A; id[0] = DW'(8'hAA);
    tick();
    ic[0] = 8'h0B; id[0] = DW'(8'hBB);
    tick();
    iv[0] = 1'b0;
    chk("bp_ir", 0, 128'(ir[0]), 128'(0));
    repeat (4) tick();
    chk("bp_od", 0, 128'(od[0]), 128'(8'hAA));
    chk("bp_sc", 0, 128'(sc[0]), 128'(5));
    chk("bp_ir2", 0, 128'(ir[0]), 128'(0));
    ordy[0] = 1'b1;
    tick();
    chk("rel_a_b", 0, 128'(od[0]), 128'(8'hBB));
    chk("rel_ir3", 0, 128'(ir[0]), 128'(1));
    tick();
    chk("rel_empty", 0, 128'(ov[0]), 128'(0));

    ordy[0] = 1'b0;
    iv[0] = 1'b1; ic[0] = 8'hFF; id[0] = DW'(1);
    tick();
    id[0] = DW'(2);
    tick();
    ordy[0] = 1'b1;
    fl[0] = 1'b1; id[0] = DW'(3);
    #1;
    chk("fl_ir", 0, 128'(ir[0]), 128'(0));
    tick();
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk("fl_ov", 0, 128'(ov[0]), 128'(0));
    chk("fl_oc", 0, 128'(oc[0]), 128'(0));
    chk("fl_sc", 0, 128'(sc[0]), 128'(6));
    tick();

    iv[1] = 1'b1; ic[1] = 8'h21; id[1] = DW'(8'h11);
    tick();
    chk("s0_od", 1, 128'(od[1]), 128'(8'h11));
    ordy[1] = 1'b0; ic[1] = 8'h22; id[1] = DW'(8'h22);
    #1;
    chk("s0_ir0", 1, 128'(ir[1]), 128'(0));
    tick();
    chk("s0_hold", 1, 128'(od[1]), 128'(8'h11));
    ordy[1] = 1'b1;
    #1;
    chk("s0_ir1", 1, 128'(ir[1]), 128'(1));
    tick();
    chk("s0_ov", 1, 128'(ov[1]), 128'(1));
    chk("s0_new", 1, 128'(od[1]), 128'(8'h22));
    iv[1] = 1'b0;
    tick();

    ordy[2] = 1'b0;
    iv[2] = 1'b1; ic[2] = 8'h33; id[2] = DW'(7);
    tick();
    iv[2] = 1'b0;
    repeat (20) tick();
    chk("sat_sc", 2, 128'(sc[2]), 128'(15));
    ordy[2] = 1'b1;
    tick();

    for (int n = 0; n < 300; n++) begin
      rst = !(n >= 150 && n < 152);
      for (int k = 0; k < N; k++) begin
        iv[k]   = $urandom_range(0, 1) == 1;
        ordy[k] = ($urandom % 4) != 0;
        fl[k]   = ($urandom % 16) == 0;
        ic[k]   = CW'($urandom());
        id[k]   = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
      end
      tick();
    end
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1;
    end
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
